// File: rtl/conv_pe_mac.sv
// Convolution PE: multiplies pixel/weight pairs, sums one KNL_SIZE*KNL_SIZE*CH_NUM window,
// then rounds, shifts, saturates and optionally ReLU-clamps into a one-entry output register.
module conv_pe_mac #(
   parameter int KNL_SIZE  = 5,
   parameter int CH_NUM    = 1,
   parameter int DATA_W    = 16,
   parameter int WGT_W     = 16,
   parameter int RES_W     = 16,
   parameter int OUT_SHIFT = 21
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              relu_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] picDat,
   input  logic [WGT_W-1:0]  weightDat,
   output logic [RES_W-1:0]  result,
   output logic              sat,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int N     = KNL_SIZE * KNL_SIZE * CH_NUM;
   localparam int LOG_N = $clog2(N);
   localparam int CNT_W = (LOG_N < 1) ? 1 : LOG_N;
   localparam int P_W   = DATA_W + WGT_W;
   localparam int ACC_W = P_W + LOG_N + 1;
   localparam int RND_W = ACC_W + 1;

   localparam logic signed [RND_W-1:0] RES_MAX = {{(RND_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
   localparam logic signed [RND_W-1:0] RES_MIN = {{(RND_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

   logic [CNT_W-1:0]        cnt_reg;
   logic signed [P_W-1:0]   p_reg;
   logic                    p_vld_reg;
   logic                    p_last_reg;
   logic signed [ACC_W-1:0] acc_reg;
   logic [RES_W-1:0]        result_reg;
   logic                    sat_reg;
   logic                    out_valid_reg;

   logic                    stall;
   logic                    accept;
   logic                    cnt_last;
   logic                    load;
   logic signed [P_W-1:0]   pic_ext;
   logic signed [P_W-1:0]   wgt_ext;
   logic signed [P_W-1:0]   p_next;
   logic signed [ACC_W-1:0] sum_full;
   logic signed [RND_W-1:0] rnd_const;
   logic signed [RND_W-1:0] rnd_in;
   logic signed [RND_W-1:0] shifted;
   logic [RES_W-1:0]        clip_val;
   logic [RES_W-1:0]        res_next;
   logic                    sat_next;

   // Backpressure freezes both pipeline stages so no term is lost while a result waits.
   assign stall    = out_valid_reg & ~out_ready;
   assign in_ready = ~stall & ~clr;
   assign accept   = in_valid & in_ready;
   assign cnt_last = (cnt_reg == CNT_W'(N - 1));

   assign pic_ext = P_W'($signed(picDat));
   assign wgt_ext = P_W'($signed(weightDat));
   assign p_next  = pic_ext * wgt_ext;

   assign load     = p_vld_reg & p_last_reg & ~stall & ~clr;
   assign sum_full = acc_reg + ACC_W'(p_reg);

   generate
      if (OUT_SHIFT > 0) begin : g_round
         assign rnd_const = {{(RND_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
      end else begin : g_no_round
         assign rnd_const = '0;
      end
   endgenerate

   assign rnd_in  = RND_W'(sum_full) + rnd_const;
   assign shifted = rnd_in >>> OUT_SHIFT;

   // ReLU acts after saturation, so a clipped negative sum still reports sat=1.
   always_comb begin
      sat_next = 1'b0;
      clip_val = shifted[RES_W-1:0];
      if (shifted > RES_MAX) begin
         clip_val = {1'b0, {(RES_W-1){1'b1}}};
         sat_next = 1'b1;
      end else if (shifted < RES_MIN) begin
         clip_val = {1'b1, {(RES_W-1){1'b0}}};
         sat_next = 1'b1;
      end
      res_next = (relu_en && clip_val[RES_W-1]) ? '0 : clip_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         p_reg      <= '0;
         p_vld_reg  <= 1'b0;
         p_last_reg <= 1'b0;
      end else if (clr) begin
         cnt_reg    <= '0;
         p_vld_reg  <= 1'b0;
         p_last_reg <= 1'b0;
      end else begin
         if (accept)
            cnt_reg <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
         if (!stall) begin
            p_reg      <= p_next;
            p_vld_reg  <= accept;
            p_last_reg <= accept & cnt_last;
         end
      end
   end

   // The last product bypasses the accumulator into the output so the next window starts at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_reg <= '0;
      else if (clr)
         acc_reg <= '0;
      else if (!stall && p_vld_reg)
         acc_reg <= p_last_reg ? '0 : sum_full;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_reg    <= '0;
         sat_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (load) begin
         result_reg    <= res_next;
         sat_reg       <= sat_next;
         out_valid_reg <= 1'b1;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign result    = result_reg;
   assign sat       = sat_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_conv_pe_mac.sv
// Bench for conv_pe_mac: a 25-term instance (no shift) and a 1-term instance (shift 4),
// checked against a window-sum model of accepted pairs plus literal expectations.
module tb_conv_pe_mac;

   localparam int NA   = 25;
   localparam int NB   = 1;
   localparam int SH_A = 0;
   localparam int SH_B = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic               a_clr, a_relu, a_valid, a_ready, a_sat, a_ovalid, a_oready;
   logic signed [15:0] a_pic, a_wgt;
   logic [15:0]        a_res;
   logic               b_clr, b_relu, b_valid, b_ready, b_sat, b_ovalid, b_oready;
   logic signed [15:0] b_pic, b_wgt;
   logic [15:0]        b_res;

   conv_pe_mac #(.KNL_SIZE(5), .CH_NUM(1), .DATA_W(16), .WGT_W(16), .RES_W(16), .OUT_SHIFT(SH_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clr(a_clr), .relu_en(a_relu),
      .in_valid(a_valid), .in_ready(a_ready), .picDat(a_pic), .weightDat(a_wgt),
      .result(a_res), .sat(a_sat), .out_valid(a_ovalid), .out_ready(a_oready));

   conv_pe_mac #(.KNL_SIZE(1), .CH_NUM(1), .DATA_W(16), .WGT_W(16), .RES_W(16), .OUT_SHIFT(SH_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clr(b_clr), .relu_en(b_relu),
      .in_valid(b_valid), .in_ready(b_ready), .picDat(b_pic), .weightDat(b_wgt),
      .result(b_res), .sat(b_sat), .out_valid(b_ovalid), .out_ready(b_oready));

   typedef struct {
      longint r;
      bit     s;
      int     t;
   } exp_t;

   exp_t   qa[$];
   exp_t   qb[$];
   exp_t   ea, eb;
   int     n_vec = 0;
   int     n_err = 0;
   int     cyc = 0;
   longint msum_a = 0;
   longint msum_b = 0;
   int     mcnt_a = 0;
   int     mcnt_b = 0;
   bit     chk_lat = 1'b1;
   longint last_a_r = 0;
   longint last_b_r = 0;
   bit     last_a_s = 1'b0;
   bit     last_b_s = 1'b0;
   int     n_out_a = 0;
   bit     prev_hold_a = 1'b0;
   logic [15:0] prev_res_a;
   logic   prev_sat_a;

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Window result from the plain arithmetic rules: round half up, shift, clip, ReLU.
   function automatic void model_f(input longint s, input int sh, input bit relu,
                                   output longint r, output bit st);
      longint v;
      v = s;
      if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
      v  = v >>> sh;
      st = 1'b0;
      if (v > 32767) begin v = 32767; st = 1'b1; end
      else if (v < -32768) begin v = -32768; st = 1'b1; end
      if (relu && v < 0) v = 0;
      r = v;
   endfunction

   // Single compare process: outputs sampled on the falling edge, when inputs are stable.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         qa.delete(); qb.delete();
         msum_a = 0; mcnt_a = 0; msum_b = 0; mcnt_b = 0;
         prev_hold_a = 1'b0;
      end else begin
         if (prev_hold_a) begin
            check("a_hold_valid", a_ovalid, 1);
            check("a_hold_result", $signed(a_res), $signed(prev_res_a));
            check("a_hold_sat", a_sat, prev_sat_a);
         end
         prev_hold_a = a_ovalid && !a_oready;
         prev_res_a  = a_res;
         prev_sat_a  = a_sat;

         if (a_ovalid && a_oready) begin
            if (qa.size() == 0) check("a_unexpected_output", qa.size(), 1);
            else begin
               ea = qa.pop_front();
               check("a_result", $signed(a_res), ea.r);
               check("a_sat", a_sat, ea.s);
               if (chk_lat) check("a_latency", cyc - ea.t, 2);
               last_a_r = $signed(a_res);
               last_a_s = a_sat;
               n_out_a++;
            end
         end
         if (b_ovalid && b_oready) begin
            if (qb.size() == 0) check("b_unexpected_output", qb.size(), 1);
            else begin
               eb = qb.pop_front();
               check("b_result", $signed(b_res), eb.r);
               check("b_sat", b_sat, eb.s);
               check("b_latency", cyc - eb.t, 2);
               last_b_r = $signed(b_res);
               last_b_s = b_sat;
            end
         end

         if (a_valid && a_ready) begin
            msum_a += longint'(a_pic) * longint'(a_wgt);
            mcnt_a++;
            if (mcnt_a == NA) begin
               model_f(msum_a, SH_A, a_relu, ea.r, ea.s);
               ea.t = cyc;
               qa.push_back(ea);
               msum_a = 0; mcnt_a = 0;
            end
         end
         if (a_clr) begin msum_a = 0; mcnt_a = 0; end
         if (b_valid && b_ready) begin
            msum_b += longint'(b_pic) * longint'(b_wgt);
            mcnt_b++;
            if (mcnt_b == NB) begin
               model_f(msum_b, SH_B, b_relu, eb.r, eb.s);
               eb.t = cyc;
               qb.push_back(eb);
               msum_b = 0; mcnt_b = 0;
            end
         end
         if (b_clr) begin msum_b = 0; mcnt_b = 0; end
      end
   end

   task automatic send(input int id, input logic signed [15:0] x, input logic signed [15:0] y);
      int k;
      k = 0;
      if (id == 0) begin a_valid = 1'b1; a_pic = x; a_wgt = y; end
      else begin b_valid = 1'b1; b_pic = x; b_wgt = y; end
      @(negedge clk);
      while (((id == 0) ? a_ready : b_ready) == 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) check("send_timeout", k, 0);
      @(posedge clk); #1;
      if (id == 0) a_valid = 1'b0; else b_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      @(posedge clk); #1;
      while ((qa.size() != 0 || qb.size() != 0) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain_pending", qa.size() + qb.size(), 0);
   endtask

   int rin[6]  = '{24, 23, -24, -25, 8, -8};
   int rexp[6] = '{2, 1, -1, -2, 1, 0};

   initial begin
      a_clr = 0; a_relu = 0; a_valid = 0; a_pic = 0; a_wgt = 0; a_oready = 1;
      b_clr = 0; b_relu = 0; b_valid = 0; b_pic = 0; b_wgt = 0; b_oready = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_result", a_res, 0);
      check("rst_a_sat", a_sat, 0);
      check("rst_a_out_valid", a_ovalid, 0);
      check("rst_b_out_valid", b_ovalid, 0);
      rst_n = 1'b1;
      #1;
      check("rst_a_in_ready", a_ready, 1);
      check("rst_b_in_ready", b_ready, 1);
      @(posedge clk); #1;

      // Two back-to-back windows of 1x1.
      repeat (2 * NA) send(0, 1, 1);
      drain();
      check("ones_result", last_a_r, 25);
      check("ones_sat", last_a_s, 0);
      check("ones_windows", n_out_a, 2);

      // Rounding on the single-term instance.
      for (int i = 0; i < 6; i++) begin
         send(1, 16'(rin[i]), 1);
         drain();
         check("round_result", last_b_r, rexp[i]);
      end

      // Saturation and its boundaries.
      repeat (NA) send(0, 32767, 32767);
      drain();
      check("sat_pos_result", last_a_r, 32767);
      check("sat_pos_sat", last_a_s, 1);
      repeat (NA) send(0, 32767, -32768);
      drain();
      check("sat_neg_result", last_a_r, -32768);
      check("sat_neg_sat", last_a_s, 1);
      send(0, 32767, 1);
      repeat (NA - 1) send(0, 0, 0);
      drain();
      check("edge_max_result", last_a_r, 32767);
      check("edge_max_sat", last_a_s, 0);
      send(0, -32768, 1);
      repeat (NA - 1) send(0, 0, 0);
      drain();
      check("edge_min_result", last_a_r, -32768);
      check("edge_min_sat", last_a_s, 0);

      // ReLU on a window summing to -5, then the same window without it.
      a_relu = 1'b1;
      repeat (5) send(0, -1, 1);
      repeat (NA - 5) send(0, 0, 7);
      drain();
      check("relu_on_result", last_a_r, 0);
      check("relu_on_sat", last_a_s, 0);
      repeat (NA) send(0, 32767, -32768);
      drain();
      check("relu_sat_result", last_a_r, 0);
      check("relu_sat_sat", last_a_s, 1);
      a_relu = 1'b0;
      repeat (5) send(0, -1, 1);
      repeat (NA - 5) send(0, 0, 7);
      drain();
      check("relu_off_result", last_a_r, -5);

      // Backpressure across two windows.
      chk_lat  = 1'b0;
      a_oready = 1'b0;
      repeat (NA) send(0, 1, 1);
      fork
         begin
            repeat (NA) send(0, 2, 2);
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            check("bp_out_valid", a_ovalid, 1);
            check("bp_in_ready", a_ready, 0);
            check("bp_held_result", $signed(a_res), 25);
            repeat (10) @(posedge clk);
            #1;
            a_oready = 1'b1;
         end
      join
      drain();
      check("bp_second_result", last_a_r, 100);
      chk_lat = 1'b1;

      // Abort a partial window, then a full 2x3 window.
      repeat (10) send(0, 5, 5);
      a_clr = 1'b1;
      @(posedge clk); #1;
      a_clr = 1'b0;
      repeat (NA) send(0, 2, 3);
      drain();
      check("clr_result", last_a_r, 150);

      // Asynchronous reset in the middle of a window.
      repeat (NA) send(0, 32767, 32767);
      drain();
      repeat (7) send(0, 1, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_result", a_res, 0);
      check("mid_rst_sat", a_sat, 0);
      check("mid_rst_out_valid", a_ovalid, 0);
      check("mid_rst_in_ready", a_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (NA) send(0, 3, -4);
      drain();
      check("post_rst_result", last_a_r, -300);
      check("post_rst_sat", last_a_s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
